// File: rtl/wb_retire_queue.sv
// Dual-lane writeback receiver: in-order FIFO, one retire per cycle
// to the register-file write port and the scoreboard release port.
module wb_retire_queue #(
  parameter int DEPTH = 4,
  parameter int SID_W = 4,
  parameter int XLEN  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst0_wb_valid_i,
  input  logic [4:0]       inst0_wb_rd_i,
  input  logic [XLEN-1:0]  inst0_wb_value_i,
  input  logic [SID_W-1:0] inst0_wb_sid_i,
  input  logic             inst1_wb_valid_i,
  input  logic [4:0]       inst1_wb_rd_i,
  input  logic [XLEN-1:0]  inst1_wb_value_i,
  input  logic [SID_W-1:0] inst1_wb_sid_i,
  output logic             stall_inst0_wb_o,
  output logic             stall_inst1_wb_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             sb_release_valid_o,
  output logic [SID_W-1:0] sb_release_sid_o,
  output logic [31:0]      retire_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       rd_q  [DEPTH];
  logic [XLEN-1:0]  val_q [DEPTH];
  logic [SID_W-1:0] sid_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wptr1;
  logic [CW-1:0]    count_q, count_d, free;
  logic             stall, acc0, acc1, pop;

  logic             rf_we_q, rel_q;
  logic [4:0]       waddr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [SID_W-1:0] rsid_q;
  logic [31:0]      ret_q, ret_d;

  // Two free slots are reserved so a dual accept can never overflow.
  assign free  = CW'(DEPTH) - count_q;
  assign stall = free < CW'(2);
  assign acc0  = inst0_wb_valid_i && !stall;
  assign acc1  = inst1_wb_valid_i && !stall;
  assign pop   = count_q != '0;
  assign wptr1 = wptr_q + AW'(acc0);

  always_comb begin
    wptr_d  = wptr_q + AW'(acc0) + AW'(acc1);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    ret_d   = ret_q + 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      rd_q[wptr_q]  <= inst0_wb_rd_i;
      val_q[wptr_q] <= inst0_wb_value_i;
      sid_q[wptr_q] <= inst0_wb_sid_i;
    end
    if (acc1) begin
      rd_q[wptr1]  <= inst1_wb_rd_i;
      val_q[wptr1] <= inst1_wb_value_i;
      sid_q[wptr1] <= inst1_wb_sid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rf_we_q <= 1'b0;
      rel_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rsid_q  <= '0;
      ret_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rf_we_q <= pop && (rd_q[rptr_q] != 5'd0);
      rel_q   <= pop;
      ret_q   <= ret_d;
      if (pop) begin
        waddr_q <= rd_q[rptr_q];
        wdata_q <= val_q[rptr_q];
        rsid_q  <= sid_q[rptr_q];
      end
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));

  assign stall_inst0_wb_o   = stall;
  assign stall_inst1_wb_o   = stall;
  assign rf_we_o            = rf_we_q;
  assign rf_waddr_o         = waddr_q;
  assign rf_wdata_o         = wdata_q;
  assign sb_release_valid_o = rel_q;
  assign sb_release_sid_o   = rsid_q;
  assign retire_cnt_o       = ret_q;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: vector table, scoreboard queue,
// backpressure streaming, reset flush and counter wrap.
module tb_wb_retire_queue;

  logic        clk, rst_n;
  logic        v0, v1;
  logic [4:0]  rd0, rd1;
  logic [63:0] val0, val1;
  logic [3:0]  sid0, sid1;
  logic        st0, st1, rf_we, rel;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [3:0]  rsid;
  logic [31:0] rcnt;

  wb_retire_queue #(.DEPTH(4), .SID_W(4), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst0_wb_valid_i(v0), .inst0_wb_rd_i(rd0),
    .inst0_wb_value_i(val0), .inst0_wb_sid_i(sid0),
    .inst1_wb_valid_i(v1), .inst1_wb_rd_i(rd1),
    .inst1_wb_value_i(val1), .inst1_wb_sid_i(sid1),
    .stall_inst0_wb_o(st0), .stall_inst1_wb_o(st1),
    .rf_we_o(rf_we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .sb_release_valid_o(rel), .sb_release_sid_o(rsid),
    .retire_cnt_o(rcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
    logic [3:0]  sid;
  } ent_t;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [63:0] val0;
    logic [3:0]  sid0;
    logic        v1;
    logic [4:0]  rd1;
    logic [63:0] val1;
    logic [3:0]  sid1;
    logic        e_rel;
    logic        e_we;
    logic [3:0]  e_sid;
  } vec_t;

  ent_t        sbq[$];
  logic [31:0] mret;
  int          errs, checks;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(
    input logic a0, input logic [4:0] r0,
    input logic [63:0] d0, input logic [3:0] s0,
    input logic a1, input logic [4:0] r1,
    input logic [63:0] d1, input logic [3:0] s1);
    logic mstall, pop;
    ent_t e;
    v0 = a0; rd0 = r0; val0 = d0; sid0 = s0;
    v1 = a1; rd1 = r1; val1 = d1; sid1 = s1;
    mstall = (4 - sbq.size()) < 2;
    chk("stall0", st0, mstall);
    chk("stall1", st1, mstall);
    pop = sbq.size() != 0;
    e = '0;
    if (pop) e = sbq.pop_front();
    if (a0 && !mstall) sbq.push_back('{r0, d0, s0});
    if (a1 && !mstall) sbq.push_back('{r1, d1, s1});
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    mret = mret + 32'(pop);
    chk("rel_valid", rel, pop);
    chk("retire_cnt", rcnt, mret);
    if (pop) begin
      chk("rel_sid", rsid, e.sid);
      chk("rf_we", rf_we, e.rd != 5'd0);
      chk("rf_waddr", waddr, e.rd);
      chk("rf_wdata", wdata, e.val);
    end else begin
      chk("rf_we_idle", rf_we, 1'b0);
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[9];

  initial begin
    errs = 0; checks = 0; mret = '0;
    rst_n = 1'b0;
    v0 = 0; rd0 = 0; val0 = 0; sid0 = 0;
    v1 = 0; rd1 = 0; val1 = 0; sid1 = 0;

    tbl[0] = '{1, 5, 64'hAA, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3};
    tbl[2] = '{1, 1, 64'h11, 0, 1, 2, 64'h22, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[4] = '{1, 0, 64'h77, 7, 0, 0, 0, 0, 1, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7};
    tbl[6] = '{0, 0, 0, 0, 1, 9, 64'h99, 5, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rel", rel, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_sid", rsid, 4'd0);
    chk("rst_cnt", rcnt, 32'd0);
    chk("rst_stall", {st0, st1}, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v0, tbl[i].rd0, tbl[i].val0, tbl[i].sid0,
            tbl[i].v1, tbl[i].rd1, tbl[i].val1, tbl[i].sid1);
      chk($sformatf("tbl%0d_rel", i), rel, tbl[i].e_rel);
      chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_rel)
        chk($sformatf("tbl%0d_sid", i), rsid, tbl[i].e_sid);
    end
    chk("tbl_retire_total", rcnt, 32'd5);

    // Streaming dual pairs; a stalled pair is held and re-presented.
    begin
      int k;
      int sawstall;
      logic held;
      k = 0;
      sawstall = 0;
      for (int c = 0; c < 20; c++) begin
        held = sbq.size() >= 3;
        if (held) sawstall++;
        cycle(1, 5'((2*k) % 31 + 1), 64'(1000 + 2*k), 4'(2*k),
              1, 5'((2*k+1) % 31 + 1), 64'(1000 + 2*k + 1), 4'(2*k+1));
        if (!held) k++;
      end
      repeat (5) idle();
      chk("stream_drained", sbq.size(), 0);
      chk("stream_saw_stall", sawstall > 0, 1'b1);
    end

    // Fill to three entries then reset: nothing may be released.
    cycle(1, 3, 64'h31, 1, 1, 4, 64'h41, 2);
    cycle(1, 5, 64'h51, 3, 1, 6, 64'h61, 4);
    chk("fill_count3_stall", st0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    mret = '0;
    chk("flush_rel", rel, 1'b0);
    chk("flush_we", rf_we, 1'b0);
    chk("flush_cnt", rcnt, 32'd0);
    chk("flush_stall", {st0, st1}, 2'b00);
    repeat (3) idle();

    // Counter wrap from all-ones.
    force dut.ret_q = 32'hFFFF_FFFF;
    mret = 32'hFFFF_FFFF;
    cycle(1, 10, 64'hBEEF, 9, 0, 0, 0, 0);
    release dut.ret_q;
    idle();
    chk("wrap_zero", rcnt, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
